// File: rtl/dm_responder_if.sv
// Handshake bundle between the CPU MEM stage (master) and the data-memory responder (slave).
interface dm_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        stall;

  modport master (
    output req, we, addr, be, wdata,
    input  req_ready, resp_valid, rdata, err, stall
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output req_ready, resp_valid, rdata, err, stall
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, performs the
// access and returns a one-cycle response while holding the pipeline stalled.
module dm_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input logic           clk,
  input logic           reset,
  dm_responder_if.slave bus
);
  localparam int MemWords = 2 ** ADDR_W;

  if (LATENCY < 0 || LATENCY > 15) begin : gLatencyCheck
    $error("dm_responder: LATENCY must be within 0..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q;
  logic [3:0]          latCnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;
  logic                oor_q;
  logic                respValid_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [31:0]         mem_q [MemWords];

  logic                accept;
  logic                reqOor;
  logic                accExec;
  logic                accWe;
  logic [ADDR_W-1:0]   accIdx;
  logic [3:0]          accBe;
  logic [31:0]         accWdata;
  logic                accOor;
  logic                unusedAddrBits;

  assign accept         = (state_q == IDLE) && bus.req;
  assign reqOor         = |bus.addr[31:ADDR_W+2];
  assign unusedAddrBits = ^bus.addr[1:0];

  // With zero latency the access fires on the acceptance edge, straight from the inputs.
  always_comb begin
    accWe    = we_q;
    accIdx   = idx_q;
    accBe    = be_q;
    accWdata = wdata_q;
    accOor   = oor_q;
    if (LATENCY == 0) begin
      accWe    = bus.we;
      accIdx   = bus.addr[ADDR_W+1:2];
      accBe    = bus.be;
      accWdata = bus.wdata;
      accOor   = reqOor;
    end
  end

  assign accExec = (LATENCY == 0) ? accept : ((state_q == WAIT) && (latCnt_q == 4'd0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      latCnt_q    <= 4'd0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      oor_q       <= 1'b0;
      respValid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      respValid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            idx_q   <= bus.addr[ADDR_W+1:2];
            be_q    <= bus.be;
            wdata_q <= bus.wdata;
            oor_q   <= reqOor;
            if (LATENCY == 0) begin
              state_q <= RESP;
            end else begin
              state_q  <= WAIT;
              latCnt_q <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (latCnt_q == 4'd0) begin
            state_q <= RESP;
          end else begin
            latCnt_q <= latCnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (accExec) begin
        respValid_q <= 1'b1;
        err_q       <= accOor;
        rdata_q     <= (!accWe && !accOor) ? mem_q[accIdx] : 32'd0;
      end
    end
  end

  // Stores land on the same edge that enters RESP, so a following load sees them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MemWords; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (accExec && accWe && !accOor) begin
      for (int b = 0; b < 4; b++) begin
        if (accBe[b]) begin
          mem_q[accIdx][8*b +: 8] <= accWdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = respValid_q;
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;
  assign bus.stall      = bus.req && !respValid_q;
endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a LATENCY=2 and a LATENCY=0 instance share clock
// and reset; every response is matched against a scoreboard filled when stimulus is driven.
module tb_dm_responder;
  localparam int ADDR_W = 10;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_responder_if busA ();
  dm_responder_if busZ ();

  dm_responder #(.ADDR_W(ADDR_W), .LATENCY(2)) dutA (.clk(clk), .reset(reset), .bus(busA.slave));
  dm_responder #(.ADDR_W(ADDR_W), .LATENCY(0)) dutZ (.clk(clk), .reset(reset), .bus(busZ.slave));

  int          errors = 0;
  int          checks = 0;
  exp_t        sbA[$];
  exp_t        sbZ[$];
  logic [31:0] modelA [2**ADDR_W];
  logic [31:0] lastRdataA = 32'd0;
  logic        lastErrA   = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset && busA.resp_valid) begin
      checks++;
      if (sbA.size() == 0) begin
        errors++;
        $display("[TB] FAIL respA_unexpected: resp_valid=1 required=0 at %0t", $time);
      end else begin
        e          = sbA.pop_front();
        lastRdataA = busA.rdata;
        lastErrA   = busA.err;
        if (busA.rdata !== e.rdata || busA.err !== e.err) begin
          errors++;
          $display("[TB] FAIL respA_data: rdata=%h err=%b required rdata=%h err=%b",
                   busA.rdata, busA.err, e.rdata, e.err);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset && busZ.resp_valid) begin
      checks++;
      if (sbZ.size() == 0) begin
        errors++;
        $display("[TB] FAIL respZ_unexpected: resp_valid=1 required=0 at %0t", $time);
      end else begin
        e = sbZ.pop_front();
        if (busZ.rdata !== e.rdata || busZ.err !== e.err) begin
          errors++;
          $display("[TB] FAIL respZ_data: rdata=%h err=%b required rdata=%h err=%b",
                   busZ.rdata, busZ.err, e.rdata, e.err);
        end
      end
    end
  end

  // One full access on the LATENCY=2 instance; inputs are scrambled once accepted.
  task automatic accessA(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
    exp_t e;
    int   idx;
    int   cyc;
    logic oor;
    @(posedge clk); #1;
    busA.req = 1'b1; busA.we = w; busA.addr = a; busA.be = b; busA.wdata = d;
    oor     = |a[31:ADDR_W+2];
    idx     = int'(a[ADDR_W+1:2]);
    e.err   = oor;
    e.rdata = (!w && !oor) ? modelA[idx] : 32'd0;
    if (w && !oor) begin
      for (int k = 0; k < 4; k++) begin
        if (b[k]) modelA[idx][8*k +: 8] = d[8*k +: 8];
      end
    end
    sbA.push_back(e);
    #1;
    checks++;
    if (busA.stall !== 1'b1 || busA.req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_stall_ready: stall=%b req_ready=%b required 1 1",
               busA.stall, busA.req_ready);
    end
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        busA.we = ~w; busA.addr = a ^ 32'h4; busA.be = ~b; busA.wdata = ~d;
      end
      if (!busA.resp_valid) begin
        checks++;
        if (busA.stall !== 1'b1 || busA.req_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL wait_stall_ready: stall=%b req_ready=%b required 1 0",
                   busA.stall, busA.req_ready);
        end
      end
    end while (!busA.resp_valid && cyc < 20);
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("[TB] FAIL latency_A: cycles=%0d required=3", cyc);
    end
    checks++;
    if (busA.stall !== 1'b0 || busA.req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL resp_stall_ready: stall=%b req_ready=%b required 0 0",
               busA.stall, busA.req_ready);
    end
    busA.req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busA.resp_valid !== 1'b0 || busA.rdata !== 32'd0 || busA.err !== 1'b0 ||
        busA.req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_resp: valid=%b rdata=%h err=%b ready=%b required 0 0 0 1",
               busA.resp_valid, busA.rdata, busA.err, busA.req_ready);
    end
  endtask

  task automatic test_reset();
    busA.req = 1'b0; busA.we = 1'b0; busA.addr = 32'd0; busA.be = 4'd0; busA.wdata = 32'd0;
    busZ.req = 1'b0; busZ.we = 1'b0; busZ.addr = 32'd0; busZ.be = 4'd0; busZ.wdata = 32'd0;
    for (int i = 0; i < 2**ADDR_W; i++) modelA[i] = 32'd0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busA.resp_valid !== 1'b0 || busA.rdata !== 32'd0 || busA.err !== 1'b0 ||
        busA.req_ready !== 1'b1 || busA.stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_A: valid=%b rdata=%h err=%b ready=%b stall=%b required 0 0 0 1 0",
               busA.resp_valid, busA.rdata, busA.err, busA.req_ready, busA.stall);
    end
    checks++;
    if (busZ.resp_valid !== 1'b0 || busZ.rdata !== 32'd0 || busZ.err !== 1'b0 ||
        busZ.req_ready !== 1'b1 || busZ.stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_Z: valid=%b rdata=%h err=%b ready=%b stall=%b required 0 0 0 1 0",
               busZ.resp_valid, busZ.rdata, busZ.err, busZ.req_ready, busZ.stall);
    end
  endtask

  task automatic test_load_after_reset();
    accessA(1'b0, 32'h0000_0010, 4'h0, 32'd0);
    checks++;
    if (lastRdataA !== 32'd0 || lastErrA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_after_reset: rdata=%h err=%b required 0 0", lastRdataA, lastErrA);
    end
  endtask

  task automatic test_full_store();
    accessA(1'b1, 32'h0000_0024, 4'hF, 32'hDEAD_BEEF);
    accessA(1'b0, 32'h0000_0024, 4'h0, 32'd0);
    checks++;
    if (lastRdataA !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL full_store: rdata=%h required=deadbeef", lastRdataA);
    end
  endtask

  task automatic test_partial_store();
    accessA(1'b1, 32'h0000_0024, 4'b0101, 32'h1122_3344);
    accessA(1'b0, 32'h0000_0024, 4'hF, 32'd0);
    checks++;
    if (lastRdataA !== 32'hDE22_BE44) begin
      errors++;
      $display("[TB] FAIL partial_store: rdata=%h required=de22be44", lastRdataA);
    end
  endtask

  task automatic test_zero_be();
    accessA(1'b1, 32'h0000_0024, 4'b0000, 32'hFFFF_FFFF);
    accessA(1'b0, 32'h0000_0024, 4'h0, 32'd0);
    checks++;
    if (lastRdataA !== 32'hDE22_BE44) begin
      errors++;
      $display("[TB] FAIL zero_be: rdata=%h required=de22be44", lastRdataA);
    end
  endtask

  task automatic test_out_of_range();
    accessA(1'b1, 32'h0000_1000, 4'hF, 32'h0000_0005);
    checks++;
    if (lastErrA !== 1'b1 || lastRdataA !== 32'd0) begin
      errors++;
      $display("[TB] FAIL oor_store: err=%b rdata=%h required 1 0", lastErrA, lastRdataA);
    end
    accessA(1'b0, 32'h0000_0000, 4'h0, 32'd0);
    checks++;
    if (lastErrA !== 1'b0 || lastRdataA !== 32'd0) begin
      errors++;
      $display("[TB] FAIL oor_word0: err=%b rdata=%h required 0 0", lastErrA, lastRdataA);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 10; n++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 4) == 0) a = a | 32'h0001_0000;
      accessA(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    busZ.req = 1'b1; busZ.we = 1'b1; busZ.addr = 32'h0000_000C; busZ.be = 4'hF;
    busZ.wdata = 32'hA5A5_0F0F;
    sbZ.push_back('{32'd0, 1'b0});
    @(posedge clk); #1;
    checks++;
    if (busZ.resp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL z_store_resp: resp_valid=%b required=1", busZ.resp_valid);
    end
    busZ.req = 1'b0;
    @(posedge clk); #1;
    busZ.req = 1'b1; busZ.we = 1'b0; busZ.addr = 32'h0000_000C; busZ.be = 4'h0;
    sbZ.push_back('{32'hA5A5_0F0F, 1'b0});
    @(posedge clk); #1;
    checks++;
    if (busZ.resp_valid !== 1'b1 || busZ.req_ready !== 1'b0 || busZ.stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_t1: valid=%b ready=%b stall=%b required 1 0 0",
               busZ.resp_valid, busZ.req_ready, busZ.stall);
    end
    busZ.addr = 32'h0000_0010;
    sbZ.push_back('{32'd0, 1'b0});
    @(posedge clk); #1;
    checks++;
    if (busZ.resp_valid !== 1'b0 || busZ.req_ready !== 1'b1 || busZ.stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_t2: valid=%b ready=%b stall=%b required 0 1 1",
               busZ.resp_valid, busZ.req_ready, busZ.stall);
    end
    @(posedge clk); #1;
    checks++;
    if (busZ.resp_valid !== 1'b1 || busZ.req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_t3: valid=%b ready=%b required 1 0", busZ.resp_valid, busZ.req_ready);
    end
    busZ.req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busZ.resp_valid !== 1'b0 || busZ.rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: valid=%b rdata=%h required 0 0", busZ.resp_valid, busZ.rdata);
    end
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    busA.req = 1'b1; busA.we = 1'b1; busA.addr = 32'h0000_0008; busA.be = 4'hF;
    busA.wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    checks++;
    if (busA.req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_wait: req_ready=%b required=0", busA.req_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset    = 1'b1;
    busA.req = 1'b0;
    for (int i = 0; i < 2**ADDR_W; i++) modelA[i] = 32'd0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (busA.resp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_resp: cycle=%0d resp_valid=%b required=0", c, busA.resp_valid);
      end
    end
    accessA(1'b0, 32'h0000_0008, 4'h0, 32'd0);
    checks++;
    if (lastRdataA !== 32'd0) begin
      errors++;
      $display("[TB] FAIL abort_load: rdata=%h required=0", lastRdataA);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_after_reset();
    test_full_store();
    test_partial_store();
    test_zero_be();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_abort();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sbA.size() != 0 || sbZ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: pendingA=%0d pendingZ=%0d required 0 0",
               sbA.size(), sbZ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder (slave) serving the MEM-stage load/store requests of the pipelined CPU.
- Accepts one request at a time over a req/ready handshake and waits a programmable number of cycles.
- Performs a byte-enabled word write or a word read, then returns a one-cycle response pulse.
- Drives a stall output so the hazard unit freezes the pipeline while an access is outstanding.

Parameters:
ADDR_W, 10, word-address width; memory holds 2**ADDR_W 32-bit words (4 KiB default)
LATENCY, 2, wait cycles between acceptance and response (0..15)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk)
req  input  1  CPU request valid; held high until resp_valid
we  input  1  1 = store, 0 = load; sampled at acceptance
addr  input  32  byte address; bits [1:0] ignored, word index = addr[ADDR_W+1:2]
be  input  4  byte enables for stores (be[0] -> bits 7:0 ... be[3] -> bits 31:24)
wdata  input  32  store data, sampled at acceptance
req_ready  output  1  high only in IDLE; request accepted when req && req_ready
resp_valid  output  1  one-cycle pulse: access complete
rdata  output  32  load data, valid with resp_valid; 0 otherwise
err  output  1  with resp_valid: address out of range
stall  output  1  combinational: req && !resp_valid

Behaviour:
- Reset (reset==0 at edge):
  - State -> IDLE; lat_cnt -> 0.
  - resp_valid=0, rdata=0, err=0; all memory words cleared to 0.
  - Captured request registers cleared.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. On req: capture we/addr/be/wdata; range check = addr[31:ADDR_W+2]!=0. Go to WAIT with lat_cnt=LATENCY-1 if LATENCY>0, else go to RESP.
  - WAIT: req_ready=0. Decrement lat_cnt; at lat_cnt==0 go to RESP.
  - RESP: req_ready=0, resp_valid=1, err=captured range flag. Next state always IDLE.
- Access timing: the access executes on the edge entering RESP.
  - Store: enabled bytes written, disabled bytes untouched.
  - Load: rdata registered with the full word.
- Latency: acceptance at edge t gives resp_valid high during cycle t+LATENCY+1. Back-to-back throughput is one access per LATENCY+2 cycles.
- Request inputs are ignored outside IDLE; changes after acceptance have no effect.
- Out-of-range access: no memory change, rdata=0, err=1 for the resp_valid cycle.
- Store with be==4'b0000: no memory change, resp_valid still pulses, err per range check.
- Load: rdata ignores be (full word). rdata returns to 0 the cycle after RESP.
- Store followed immediately by load of the same word returns the newly written data (no bypass needed: the write has completed before the next acceptance).
- Reset mid-operation (in WAIT or RESP): pending access aborted. A store not yet executed is discarded; no resp_valid.
- req low in IDLE: stays in IDLE, outputs hold reset values.
- stall: stays high from the first cycle req rises until the resp_valid cycle, inclusive of the WAIT cycles. It drops in the resp_valid cycle so the pipeline advances on that edge.
- Counter width: 4 bits. LATENCY > 15 is illegal (compile-time check).

Test Plan:
- Reset then load: reset=0 for 2 cycles; load addr=0x0000_0010, LATENCY=2 -> resp_valid in 3rd cycle after acceptance; rdata=0; err=0; stall high 3 cycles then low.
- Full store then load: store addr=0x24, be=4'hF, wdata=0xDEADBEEF; then load 0x24 -> rdata=0xDEADBEEF.
- Partial store: word 0x24 = 0xDEADBEEF; store be=4'b0101, wdata=0x11223344 -> subsequent load returns 0xDE22BE44.
- Out of range: store addr=0x0000_1000 (ADDR_W=10), wdata=0x5 -> resp_valid with err=1, rdata=0; load word 0 still 0.
- LATENCY=0 back-to-back: two loads with req held -> resp_valid at t+1 and t+3; req_ready low at t+1, high at t+2.
- Abort: store 0x8/0xCAFEF00D accepted; reset=0 during WAIT -> no resp_valid. After release, load 0x8 -> 0.
